stopwatch_core: RTL and testbench

//  MM:SS stopwatch/timer core: BCD counters, 1 Hz and adjust prescalers, pause toggle and field adjust.
//  New relative to the fixed-rate stopwatch: count-down mode with a terminal 'done' flag,

---
 rtl/stopwatch_core.sv | 161 ++++++++++++++++
 tb/tb_stopwatch_core.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch/timer core: BCD minute/second counters with up/down counting,
// field adjust with blink mask, pause toggle and free-running prescalers.
module stopwatch_core #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int ADJ_HZ   = 2,
  parameter int BLINK_HZ = 2,
  parameter int MIN_MAX  = 99
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pause_i,
  input  logic       adj_i,
  input  logic       sel_i,
  input  logic       dir_i,
  output logic [3:0] min_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic [1:0] blank_o,
  output logic       running_o,
  output logic       done_o,
  output logic       wrap_o,
  output logic       tick_1hz_o
);

  localparam int ADJ_DIV = CLK_HZ / ADJ_HZ;
  localparam int BLK_DIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int W1 = (CLK_HZ  > 1) ? $clog2(CLK_HZ)  : 1;
  localparam int WA = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
  localparam int WB = (BLK_DIV > 1) ? $clog2(BLK_DIV) : 1;

  localparam logic [7:0] SEC_TOP = 8'h59;
  localparam logic [7:0] MIN_TOP = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};

  typedef enum logic [1:0] {M_HOLD, M_RUN, M_ADJUST} mode_e;

  // Two-digit BCD step helpers; top is the wrap point of the field.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)           return 8'h00;
    else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] top);
    if (v == 8'h00)          return top;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [W1-1:0] cnt1_q, cnt1_d;
  logic [WA-1:0] cnta_q, cnta_d;
  logic [WB-1:0] cntb_q, cntb_d;
  logic          tick_q, tick_d;
  logic          adj_tick_q, adj_tick_d;
  logic          blink_q, blink_d;
  logic          pause_q;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          wrap_q, wrap_d;
  logic [1:0]    blank_q, blank_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    sec_q, sec_d;
  mode_e         mode;

  // Prescalers free-run; strobes are registered so they are one cycle wide.
  always_comb begin
    tick_d     = (cnt1_q == W1'(CLK_HZ - 1));
    cnt1_d     = tick_d ? '0 : cnt1_q + 1'b1;
    adj_tick_d = (cnta_q == WA'(ADJ_DIV - 1));
    cnta_d     = adj_tick_d ? '0 : cnta_q + 1'b1;
    blink_d    = blink_q ^ (cntb_q == WB'(BLK_DIV - 1));
    cntb_d     = (cntb_q == WB'(BLK_DIV - 1)) ? '0 : cntb_q + 1'b1;
    running_d  = running_q ^ (pause_i & ~pause_q);
    blank_d    = adj_i ? (sel_i ? {1'b0, blink_d} : {blink_d, 1'b0}) : 2'b00;
  end

  always_comb begin
    if (adj_i)          mode = M_ADJUST;
    else if (running_q) mode = M_RUN;
    else                mode = M_HOLD;
  end

  // Timekeeping uses running_q, i.e. the value before any same-cycle pause toggle.
  always_comb begin
    min_d  = min_q;
    sec_d  = sec_q;
    done_d = done_q;
    wrap_d = 1'b0;
    unique case (mode)
      M_ADJUST: begin
        done_d = 1'b0;
        if (adj_tick_q) begin
          if (sel_i) sec_d = bcd_inc(sec_q, SEC_TOP);
          else       min_d = bcd_inc(min_q, MIN_TOP);
        end
      end
      M_RUN: begin
        if (tick_q) begin
          if (!dir_i) begin
            sec_d = bcd_inc(sec_q, SEC_TOP);
            if (sec_q == SEC_TOP) begin
              min_d  = bcd_inc(min_q, MIN_TOP);
              wrap_d = (min_q == MIN_TOP);
            end
          end else if (min_q == 8'h00 && sec_q == 8'h00) begin
            done_d = 1'b1;
          end else begin
            sec_d = bcd_dec(sec_q, SEC_TOP);
            if (sec_q == 8'h00) min_d = bcd_dec(min_q, MIN_TOP);
            if (min_q == 8'h00 && sec_q == 8'h01) done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (!dir_i) done_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt1_q     <= '0;
      cnta_q     <= '0;
      cntb_q     <= '0;
      tick_q     <= 1'b0;
      adj_tick_q <= 1'b0;
      blink_q    <= 1'b0;
      pause_q    <= 1'b0;
      running_q  <= 1'b1;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      blank_q    <= 2'b00;
      min_q      <= 8'h00;
      sec_q      <= 8'h00;
    end else begin
      cnt1_q     <= cnt1_d;
      cnta_q     <= cnta_d;
      cntb_q     <= cntb_d;
      tick_q     <= tick_d;
      adj_tick_q <= adj_tick_d;
      blink_q    <= blink_d;
      pause_q    <= pause_i;
      running_q  <= running_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      blank_q    <= blank_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
    end
  end

  assign min_tens_o = min_q[7:4];
  assign min_ones_o = min_q[3:0];
  assign sec_tens_o = sec_q[7:4];
  assign sec_ones_o = sec_q[3:0];
  assign blank_o    = blank_q;
  assign running_o  = running_q;
  assign done_o     = done_q;
  assign wrap_o     = wrap_q;
  assign tick_1hz_o = tick_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core at CLK_HZ=8: vector table for up-count/pause,
// hand sequences for adjust, wrap, count-down, borrow and pause-on-tick.
module tb_stopwatch_core;
  logic       clk, rst, pause, adj, sel, dir;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [1:0] blank;
  logic       running, done, wrap, tick;

  int vecs = 0;
  int errs = 0;

  stopwatch_core #(.CLK_HZ(8), .ADJ_HZ(2), .BLINK_HZ(2), .MIN_MAX(99)) dut (
    .clk_i(clk), .rst_i(rst), .pause_i(pause), .adj_i(adj), .sel_i(sel), .dir_i(dir),
    .min_tens_o(min_tens), .min_ones_o(min_ones), .sec_tens_o(sec_tens), .sec_ones_o(sec_ones),
    .blank_o(blank), .running_o(running), .done_o(done), .wrap_o(wrap), .tick_1hz_o(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic p, a, s, d;
    int   cyc;
    int   emin, esec;
    logic erun, edone, etick;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // {min, sec, running, done, wrap, tick, blank}
  function automatic logic [21:0] mk(input int m, input int s, input logic r, input logic dn,
                                     input logic w, input logic t, input logic [1:0] b);
    return {bcd(m), bcd(s), r, dn, w, t, b};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [21:0] exp);
    logic [21:0] obs;
    obs = {min_tens, min_ones, sec_tens, sec_ones, running, done, wrap, tick, blank};
    vecs++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h%h:%h%h run=%b done=%b wrap=%b tick=%b blank=%b, want %h:%h run=%b done=%b wrap=%b tick=%b blank=%b",
               nm, min_tens, min_ones, sec_tens, sec_ones, running, done, wrap, tick, blank,
               exp[21:14], exp[13:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic do_reset(input string nm);
    pause = 0; adj = 0; sel = 0; dir = 0;
    rst = 1;
    step(1);
    rst = 0;
    chk(nm, mk(0, 0, 1, 0, 0, 0, 2'b00));
  endtask

  initial begin
    // cycle counts are edges after reset release; 1 Hz strobe visible when n%8==0
    tbl[0]  = '{0,0,0,0, 7,  0, 0, 1,0,0};
    tbl[1]  = '{0,0,0,0, 1,  0, 0, 1,0,1};
    tbl[2]  = '{0,0,0,0, 1,  0, 1, 1,0,0};
    tbl[3]  = '{0,0,0,0, 7,  0, 1, 1,0,1};
    tbl[4]  = '{0,0,0,0, 1,  0, 2, 1,0,0};
    tbl[5]  = '{0,0,0,0, 64, 0,10, 1,0,0};
    tbl[6]  = '{1,0,0,0, 3,  0,10, 0,0,0};
    tbl[7]  = '{0,0,0,0, 38, 0,10, 0,0,0};
    tbl[8]  = '{1,0,0,0, 1,  0,10, 1,0,0};
    tbl[9]  = '{0,0,0,0, 5,  0,10, 1,0,1};
    tbl[10] = '{0,0,0,0, 1,  0,11, 1,0,0};
    tbl[11] = '{0,0,0,1, 7,  0,11, 1,0,1};
    tbl[12] = '{0,0,0,1, 1,  0,10, 1,0,0};
    tbl[13] = '{0,0,0,0, 8,  0,11, 1,0,0};

    do_reset("reset_state");
    for (int i = 0; i < 14; i++) begin
      pause = tbl[i].p; adj = tbl[i].a; sel = tbl[i].s; dir = tbl[i].d;
      step(tbl[i].cyc);
      chk($sformatf("vec%0d", i),
          mk(tbl[i].emin, tbl[i].esec, tbl[i].erun, tbl[i].edone, 1'b0, tbl[i].etick, 2'b00));
    end

    // seconds adjust across 59->00 with no minute carry, blink every 2 cycles
    do_reset("reset_adj_sec");
    adj = 1; sel = 1;
    step(228);
    for (int k = 229; k <= 248; k++) begin
      step(1);
      chk($sformatf("adj_sec_n%0d", k),
          mk(0, ((k - 1) / 4) % 60, 1, 0, 0, (k % 8 == 0), {1'b0, 1'((k >> 1) & 1)}));
    end

    // preload 99:59 then up-count wrap
    do_reset("reset_preload");
    adj = 1; sel = 1;
    step(237);
    chk("preload_sec", mk(0, 59, 1, 0, 0, 0, 2'b00));
    sel = 0;
    step(396);
    chk("preload_min", mk(99, 59, 1, 0, 0, 0, 2'b00));
    adj = 0;
    step(7);
    chk("pre_wrap", mk(99, 59, 1, 0, 0, 1, 2'b00));
    step(1);
    chk("wrap_pulse", mk(0, 0, 1, 0, 1, 0, 2'b00));
    step(1);
    chk("wrap_clear", mk(0, 0, 1, 0, 0, 0, 2'b00));

    // count-down to done, hold, then dir=0 clears done
    do_reset("reset_down");
    adj = 1; sel = 1;
    step(12);
    chk("down_load", mk(0, 2, 1, 0, 0, 0, 2'b00));
    adj = 0; dir = 1;
    step(4);
    chk("down_tick", mk(0, 2, 1, 0, 0, 1, 2'b00));
    step(1);
    chk("down_01", mk(0, 1, 1, 0, 0, 0, 2'b00));
    step(8);
    chk("down_done", mk(0, 0, 1, 1, 0, 0, 2'b00));
    step(9);
    chk("down_hold", mk(0, 0, 1, 1, 0, 0, 2'b00));
    dir = 0;
    step(1);
    chk("done_clear", mk(0, 0, 1, 0, 0, 0, 2'b00));
    step(6);
    chk("up_again", mk(0, 1, 1, 0, 0, 0, 2'b00));

    // minute borrow 01:00 -> 00:59
    do_reset("reset_borrow");
    adj = 1; sel = 0;
    step(8);
    chk("borrow_load", mk(1, 0, 1, 0, 0, 1, 2'b00));
    adj = 0; dir = 1;
    step(1);
    chk("borrow_59", mk(0, 59, 1, 0, 0, 0, 2'b00));
    step(8);
    chk("borrow_58", mk(0, 58, 1, 0, 0, 0, 2'b00));

    // pause edge coincident with 1 Hz strobe, then reset mid-count
    do_reset("reset_ptick");
    step(8);
    chk("ptick_pre", mk(0, 0, 1, 0, 0, 1, 2'b00));
    pause = 1;
    step(1);
    chk("ptick_inc", mk(0, 1, 0, 0, 0, 0, 2'b00));
    pause = 0;
    step(16);
    chk("ptick_hold", mk(0, 1, 0, 0, 0, 0, 2'b00));
    do_reset("reset_midcount");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
